// File: rtl/sid_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sid_audio_pkg
//  Purpose  : Shared widths, rounding constant, saturation limits and the
//             final saturate helper for the SID audio decimator.
//  Ports    : (package, no ports)
//  Revision : 1.0  initial release
// ============================================================================
package sid_audio_pkg;

  localparam int c_IN_W      = 18;  // SID filter sample width
  localparam int c_OUT_W     = 16;  // decimated output word width
  localparam int c_RND_SHIFT = 2;   // final scale-down after rounding

  typedef logic signed [c_OUT_W-1:0] out_word_t;

  // Round-half-up constant for the final >>> c_RND_SHIFT.
  localparam logic signed [c_IN_W:0] c_RND     = 19'sd2;
  localparam out_word_t              c_SAT_MAX = 16'sh7FFF;
  localparam out_word_t              c_SAT_MIN = 16'sh8000;

  // Clamp a 19-bit signed value to 16 bits. It fits when the bits above
  // the 16-bit sign bit are all copies of it.
  function automatic out_word_t sat_out(input logic signed [c_IN_W:0] v);
    if ((&v[c_IN_W:c_OUT_W-1]) || !(|v[c_IN_W:c_OUT_W-1]))
      return v[c_OUT_W-1:0];
    else if (v[c_IN_W])
      return c_SAT_MIN;
    else
      return c_SAT_MAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sid_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sid_sample_fifo
//  Purpose  : Small synchronous FIFO with first-word-fall-through head.
//  Ports    : clk, reset_n     - clock, async active-low reset
//             push, push_data  - write request/data (ignored when full
//                                unless a pop happens on the same edge)
//             pop              - remove head (ignored when empty)
//             head_data        - current head word, 0 when empty
//             full, empty      - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module sid_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = $clog2(DEPTH);

  // One extra pointer bit tells full (MSBs differ) from empty (equal).
  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_pop;
  logic               w_push;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                  (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push on a full FIFO is kept.
  assign w_push = push && (!full || w_pop);

  assign head_data = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sid_audio_decim.sv
`default_nettype none
// ============================================================================
//  Module   : sid_audio_decim
//  Purpose  : Box-car decimator for SID filter audio. Sums 2^LOG2_DECIM
//             strobed samples, averages, rounds to 16 bits with saturation
//             and queues the words in an output FIFO.
//  Ports    : clk, reset_n         - clock, async active-low reset
//             en                   - decimator enable
//             ce_sample, audio     - sample strobe and 18-bit signed sample
//             clr_ovf              - clear sticky overflow
//             out_data, out_valid,
//             out_ready            - output word handshake
//             ovf                  - sticky: a finished word was dropped
//  Revision : 1.0  initial release
// ============================================================================
module sid_audio_decim
  import sid_audio_pkg::*;
#(
  parameter int LOG2_DECIM = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      ce_sample,
  input  logic signed [c_IN_W-1:0]  audio,
  input  logic                      clr_ovf,
  output logic signed [c_OUT_W-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      ovf
);

  localparam int c_ACC_W = c_IN_W + LOG2_DECIM;

  logic signed [c_ACC_W-1:0] r_acc;
  logic signed [c_ACC_W-1:0] r_sum;
  logic [LOG2_DECIM-1:0]     r_cnt;
  logic                      r_pend;
  logic                      r_ovf;

  logic signed [c_ACC_W-1:0] w_audio_ext;
  logic signed [c_ACC_W-1:0] w_acc_next;
  logic                      w_last;
  logic signed [c_ACC_W-1:0] w_mean_full;
  logic signed [c_IN_W:0]    w_mean;
  logic signed [c_IN_W:0]    w_rnd;
  logic signed [c_IN_W:0]    w_q;
  out_word_t                 w_word;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  logic                      w_drop;

  assign w_audio_ext = {{LOG2_DECIM{audio[c_IN_W-1]}}, audio};
  assign w_acc_next  = r_acc + w_audio_ext;
  assign w_last      = (r_cnt == {LOG2_DECIM{1'b1}});

  // Window accumulation. The closing sample goes straight into r_sum so
  // the next window can start on the very next strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= 1'b0;
      if (!en) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (ce_sample) begin
        if (w_last) begin
          r_sum  <= w_acc_next;
          r_pend <= 1'b1;
          r_acc  <= '0;
          r_cnt  <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Mean of the window fits in c_IN_W bits; one extra bit absorbs the
  // rounding add before the final shift and saturation.
  assign w_mean_full = r_sum >>> LOG2_DECIM;
  assign w_mean      = w_mean_full[c_IN_W:0];
  assign w_rnd       = w_mean + c_RND;
  assign w_q         = w_rnd >>> c_RND_SHIFT;
  assign w_word      = sat_out(w_q);

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign w_drop    = r_pend && w_full && !w_pop;

  sid_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_OUT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (r_pend),
    .push_data (w_word),
    .pop       (w_pop),
    .head_data (out_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  // A drop on the same edge as a clear wins, so no lost word goes unseen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sid_audio_decim.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sid_audio_decim
//  Purpose  : Directed self-checking bench for sid_audio_decim. Expected
//             output words are queued when a window is driven; a monitor
//             pops and compares each word the DUT hands over.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sid_audio_decim;

  logic               clk;
  logic               reset_n;
  logic               en;
  logic               ce_sample;
  logic signed [17:0] audio;
  logic               clr_ovf;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               ovf;

  int n_vec;
  int n_err;
  int n_pops;
  int pops_before;
  logic [15:0] sb[$];

  sid_audio_decim #(
    .LOG2_DECIM (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .ce_sample (ce_sample),
    .audio     (audio),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All stimulus changes happen 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [17:0] a);
    ce_sample = 1'b1;
    audio     = a;
    tick();
    ce_sample = 1'b0;
  endtask

  task automatic window(input logic [17:0] a, input logic [15:0] exp, input bit keep);
    for (int i = 0; i < 16; i++) strobe(a);
    if (keep) sb.push_back(exp);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk("drain_empty", sb.size(), 0);
    tick();
    chk("drain_valid_low", {31'd0, out_valid}, 0);
  endtask

  // Scoreboard monitor: a word transfers on the edge after this negedge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        chk("out_word", {16'd0, out_data}, {16'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0; n_err = 0; n_pops = 0;
    reset_n = 1'b0; en = 1'b0; ce_sample = 1'b0; audio = '0;
    clr_ovf = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data",  {16'd0, out_data}, 0);
    chk("rst_ovf",   {31'd0, ovf}, 0);
    tick(); tick();
    reset_n = 1'b1;
    en      = 1'b1;
    tick();

    // Basic window and output latency.
    window(18'h00400, 16'h0100, 1);
    chk("valid_not_yet", {31'd0, out_valid}, 0);
    tick();
    chk("valid_2clk", {31'd0, out_valid}, 1);
    tick();
    chk("valid_popped", {31'd0, out_valid}, 0);

    // Saturation both ways, then one strobe held high for 16 cycles.
    window(18'h1FFFF, 16'h7FFF, 1);
    window(18'h20000, 16'h8000, 1);
    ce_sample = 1'b1;
    audio     = 18'h00800;
    repeat (16) tick();
    ce_sample = 1'b0;
    sb.push_back(16'h0200);
    drain();

    // Back-pressure: four words held in order, fifth dropped.
    out_ready = 1'b0;
    window(18'h00400, 16'h0100, 1);
    window(18'h00800, 16'h0200, 1);
    window(18'h3FC00, 16'hFF00, 1);
    window(18'h00006, 16'h0002, 1);
    window(18'h00100, 16'h0040, 0);
    tick(); tick();
    chk("ovf_set",    {31'd0, ovf}, 1);
    chk("head_held",  {16'd0, out_data}, 32'h0100);
    chk("full_valid", {31'd0, out_valid}, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 0);
    drain();

    // Full FIFO with a pop on the push edge: nothing lost.
    out_ready = 1'b0;
    window(18'h00C00, 16'h0300, 1);
    window(18'h01000, 16'h0400, 1);
    window(18'h01400, 16'h0500, 1);
    window(18'h01800, 16'h0600, 1);
    window(18'h01C00, 16'h0700, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("ovf_no_drop", {31'd0, ovf}, 0);
    pops_before = n_pops;
    drain();
    chk("occupancy_4", n_pops - pops_before, 4);

    // Reset mid-window discards FIFO contents and partial sum.
    out_ready = 1'b0;
    window(18'h1FFFF, 16'h7FFF, 0);
    for (int i = 0; i < 7; i++) strobe(18'h1FFFF);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_data",  {16'd0, out_data}, 0);
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    window(18'h00400, 16'h0100, 1);
    drain();

    // Disable mid-window discards the partial sum; strobes while
    // disabled are ignored; a pending word still pushes after en drops.
    for (int i = 0; i < 10; i++) strobe(18'h01000);
    en = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) strobe(18'h01000);
    en = 1'b1;
    tick();
    window(18'h00400, 16'h0100, 1);
    en = 1'b0;
    tick();
    chk("pend_push_en0", {31'd0, out_valid}, 1);
    drain();
    en = 1'b1;

    chk("sb_final_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
